// File: rtl/uart_tx_word_serializer_if.sv
// Purpose: bundles upstream request/completion and byte-level UART TX signals.
// Latency: none; wires only.
// Backpressure: none; the byte TX paces the transfer through i_byte_tx_done.
interface uart_tx_word_serializer_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
);
  logic [NB_DATA-1:0] i_data;
  logic               i_tx_8b_start;
  logic               i_tx_32b_start;
  logic               i_byte_tx_done;
  logic [NB_BYTE-1:0] o_byte_data;
  logic               o_byte_tx_start;
  logic               o_tx_8b_done;
  logic               o_tx_32b_done;
  logic               o_tx_done;
  logic               o_busy;
  logic               o_timeout;

  // Serializer side.
  modport slave (
    input  i_data, i_tx_8b_start, i_tx_32b_start, i_byte_tx_done,
    output o_byte_data, o_byte_tx_start, o_tx_8b_done, o_tx_32b_done,
           o_tx_done, o_busy, o_timeout
  );

  // Upstream FSM / byte TX side.
  modport master (
    output i_data, i_tx_8b_start, i_tx_32b_start, i_byte_tx_done,
    input  o_byte_data, o_byte_tx_start, o_tx_8b_done, o_tx_32b_done,
           o_tx_done, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_word_serializer.sv
// Purpose: splits an 8b or 32b request into byte TX requests, LSB byte first.
// Latency: first o_byte_tx_start 1 cycle after start; next byte 1 cycle after each byte done.
// Backpressure: starts ignored while busy or in DONE; optional watchdog via UART_TX_WORD_TIMEOUT_EN.
module uart_tx_word_serializer #(
  parameter int unsigned           NB_DATA        = 32,
  parameter int unsigned           NB_BYTE        = 8,
  parameter int unsigned           NB_STATE       = 3,
  parameter int unsigned           NB_TIMEOUT     = 24,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  uart_tx_word_serializer_if.slave bus
);

  localparam int unsigned N_BYTES  = NB_DATA / NB_BYTE;
  localparam int unsigned NB_COUNT = $clog2(N_BYTES + 1);
  localparam logic [NB_COUNT-1:0] CNT_WORD = NB_COUNT'(N_BYTES);
  localparam logic [NB_COUNT-1:0] CNT_ONE  = NB_COUNT'(1);

  typedef enum logic [NB_STATE-1:0] {
    IDLE      = NB_STATE'(0),
    SEND_BYTE = NB_STATE'(1),
    WAIT_BYTE = NB_STATE'(2),
    DONE      = NB_STATE'(3)
  } state_t;

  state_t              state, state_next;
  logic [NB_DATA-1:0]  shift_reg, shift_next;
  logic [NB_COUNT-1:0] byte_cnt, cnt_next;
  logic                is_32b, is_32b_next;

  logic [NB_BYTE-1:0]  byte_data_q, byte_data_next;
  logic                byte_tx_start_q, byte_tx_start_next;
  logic                tx_8b_done_q, tx_8b_done_next;
  logic                tx_32b_done_q, tx_32b_done_next;
  logic                tx_done_q, tx_done_next;
  logic                busy_q, busy_next;

`ifdef UART_TX_WORD_TIMEOUT_EN
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;
  logic [NB_TIMEOUT-1:0] wd_cnt, wd_next;
  logic                  timeout_q, timeout_next;
`endif

  // Next-state, datapath and registered-output values; every target defaulted first.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    cnt_next    = byte_cnt;
    is_32b_next = is_32b;
`ifdef UART_TX_WORD_TIMEOUT_EN
    timeout_next = timeout_q;
    wd_next      = wd_cnt;
`endif

    case (state)
      IDLE: begin
        // A simultaneous 8b request is dropped in favour of the full word.
        if (bus.i_tx_32b_start) begin
          shift_next  = bus.i_data;
          cnt_next    = CNT_WORD;
          is_32b_next = 1'b1;
          state_next  = SEND_BYTE;
`ifdef UART_TX_WORD_TIMEOUT_EN
          timeout_next = 1'b0;
`endif
        end else if (bus.i_tx_8b_start) begin
          shift_next  = NB_DATA'(bus.i_data[NB_BYTE-1:0]);
          cnt_next    = CNT_ONE;
          is_32b_next = 1'b0;
          state_next  = SEND_BYTE;
`ifdef UART_TX_WORD_TIMEOUT_EN
          timeout_next = 1'b0;
`endif
        end
      end
      SEND_BYTE: begin
        state_next = WAIT_BYTE;
`ifdef UART_TX_WORD_TIMEOUT_EN
        wd_next = '0;
`endif
      end
      WAIT_BYTE: begin
`ifdef UART_TX_WORD_TIMEOUT_EN
        wd_next = wd_cnt + 1'b1;
`endif
        if (bus.i_byte_tx_done) begin
          shift_next = shift_reg >> NB_BYTE;
          cnt_next   = byte_cnt - CNT_ONE;
          state_next = (byte_cnt == CNT_ONE) ? DONE : SEND_BYTE;
        end
`ifdef UART_TX_WORD_TIMEOUT_EN
        else if (wd_cnt == TIMEOUT_LAST) begin
          // Skip the remaining bytes but still complete, so upstream never hangs.
          cnt_next     = '0;
          state_next   = DONE;
          timeout_next = 1'b1;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    byte_tx_start_next = (state_next == SEND_BYTE);
    byte_data_next     = (state_next == SEND_BYTE) ? shift_next[NB_BYTE-1:0] : byte_data_q;
    tx_32b_done_next   = (state_next == DONE) &&  is_32b_next;
    tx_8b_done_next    = (state_next == DONE) && !is_32b_next;
    tx_done_next       = (state_next == DONE);
    busy_next          = (state_next == SEND_BYTE) || (state_next == WAIT_BYTE);
  end

  // State, datapath and output registers; reset aborts any transfer silently.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= IDLE;
      shift_reg       <= '0;
      byte_cnt        <= '0;
      is_32b          <= 1'b0;
      byte_data_q     <= '0;
      byte_tx_start_q <= 1'b0;
      tx_8b_done_q    <= 1'b0;
      tx_32b_done_q   <= 1'b0;
      tx_done_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state           <= state_next;
      shift_reg       <= shift_next;
      byte_cnt        <= cnt_next;
      is_32b          <= is_32b_next;
      byte_data_q     <= byte_data_next;
      byte_tx_start_q <= byte_tx_start_next;
      tx_8b_done_q    <= tx_8b_done_next;
      tx_32b_done_q   <= tx_32b_done_next;
      tx_done_q       <= tx_done_next;
      busy_q          <= busy_next;
    end
  end

`ifdef UART_TX_WORD_TIMEOUT_EN
  // Per-byte watchdog and sticky abort flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt    <= wd_next;
      timeout_q <= timeout_next;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  // Watchdog not built: the configuration parameters have no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, NB_TIMEOUT};
  assign bus.o_timeout      = 1'b0;
`endif

  assign bus.o_byte_data     = byte_data_q;
  assign bus.o_byte_tx_start = byte_tx_start_q;
  assign bus.o_tx_8b_done    = tx_8b_done_q;
  assign bus.o_tx_32b_done   = tx_32b_done_q;
  assign bus.o_tx_done       = tx_done_q;
  assign bus.o_busy          = busy_q;

endmodule

// File: doc/uart_tx_word_serializer.md
Name: uart_tx_word_serializer

Overview:
- Sits between the debug unit transmit FSM (upstream) and the byte-level UART transmitter (downstream).
- Accepts either a 32-bit word or a single byte plus a start pulse, and latches the operand.
- Issues one byte-level transmit request per byte and waits for each byte-done before issuing the next.
- Returns a one-cycle completion pulse per request (8b, 32b, any) to the upstream FSM.

Parameters:
- NB_DATA, 32, word width; must be a multiple of NB_BYTE.
- NB_BYTE, 8, UART byte width.
- NB_STATE, 3, state register width.
- NB_TIMEOUT, 24, width of the per-byte watchdog counter (used only with the optional feature).
- TIMEOUT_CYCLES, 24'd10_000_000, cycles allowed per byte before abort (used only with the optional feature).

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  NB_DATA  operand; for 8b requests only [7:0] is used; sampled on the start cycle.
- i_tx_8b_start  in  1  request to send i_data[7:0].
- i_tx_32b_start  in  1  request to send all of i_data.
- i_byte_tx_done  in  1  one-cycle pulse from the UART byte TX when a byte has finished.
- o_byte_data  out  NB_BYTE  byte presented to the UART byte TX.
- o_byte_tx_start  out  1  one-cycle pulse to the UART byte TX.
- o_tx_8b_done  out  1  one-cycle pulse when an 8b request completes.
- o_tx_32b_done  out  1  one-cycle pulse when a 32b request completes.
- o_tx_done  out  1  OR of both done pulses.
- o_busy  out  1  high from the cycle after an accepted start until the done pulse cycle (exclusive).
- o_timeout  out  1  sticky abort flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset: all outputs 0, internal shift register 0, byte counter 0, state IDLE. Reset mid-transfer aborts silently, with no done pulse.
- States: IDLE, SEND_BYTE, WAIT_BYTE, DONE. All outputs are registered.
- IDLE:
  - On i_tx_32b_start: latch i_data, set byte count to 4, go to SEND_BYTE.
  - On i_tx_8b_start alone: latch i_data[7:0], set count to 1, go to SEND_BYTE.
  - Both starts high in the same cycle: 32b wins; 8b is dropped.
- SEND_BYTE: o_byte_data = shift[7:0], o_byte_tx_start pulses for exactly one cycle, go to WAIT_BYTE.
- Latency: start seen at edge N; o_byte_tx_start high and byte0 valid in cycle N+1.
- Byte order: little-endian; byte0 = bits [7:0] and goes first.
- o_byte_data holds its value from SEND_BYTE until the next SEND_BYTE.
- WAIT_BYTE: on i_byte_tx_done, shift right by 8 and decrement count.
  - Count becomes 0: go to DONE.
  - Otherwise: go to SEND_BYTE. The next o_byte_tx_start occurs 1 cycle after the done pulse.
- DONE: pulse o_tx_32b_done or o_tx_8b_done (matching the request type) plus o_tx_done for one cycle, then go to IDLE.
- Back-to-back: a start present in the DONE cycle is ignored; the upstream FSM must issue it again from IDLE. The earliest new start is accepted the cycle after the done pulse.
- Start pulses while o_busy is high are ignored, with no queueing.
- i_byte_tx_done outside WAIT_BYTE is ignored.
- The state decode default is IDLE with all pulses 0.

Optional Feature:
- Macro: UART_TX_WORD_TIMEOUT_EN.
- Defined:
  - The watchdog counter clears on each SEND_BYTE and increments in WAIT_BYTE.
  - Reaching TIMEOUT_CYCLES-1 without i_byte_tx_done aborts the transfer: remaining bytes are skipped, the normal DONE pulse is produced (so the upstream never hangs), and o_timeout is set.
  - o_timeout stays high until the next accepted start or reset.
- Undefined: no counter; WAIT_BYTE waits indefinitely; o_timeout constant 0.

Test Plan:
- 32b send: i_data=32'hDEADBEEF with 32b start, UART model returns done 5 cycles after each start -> bytes EF, BE, AD, DE in order; exactly 4 o_byte_tx_start pulses; one o_tx_32b_done and one o_tx_done pulse; o_tx_8b_done stays 0.
- 8b send: i_data=32'h12345678 with 8b start -> single byte 78; o_tx_8b_done pulses once; o_busy high for the whole transfer.
- Simultaneous starts and busy starts: 8b and 32b asserted together with i_data=32'h01020304 -> 4 bytes 04, 03, 02, 01. Extra 32b starts during the transfer -> ignored, still only 4 bytes.
- Stray and reset cases: i_byte_tx_done in IDLE -> no outputs. Reset asserted after byte 2 of 32'hCAFEF00D -> all outputs 0 next cycle, no done pulse, next start sends 0D first.
- Back-to-back: 32b start asserted the cycle after o_tx_32b_done with i_data=32'hA5A5_5A5A -> new transfer starts; o_byte_tx_start one cycle later with byte 5A.
- UART_TX_WORD_TIMEOUT_EN with TIMEOUT_CYCLES=16: UART model never returns done -> done pulse about 18 cycles after the first byte start; o_timeout=1 and stays high until the next start clears it.
